bcd_stopwatch_ctrl: RTL
=======================

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_asyn, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick, input, 1 bit: count-enable strobe, one clk wide (time base, e.g. 10 ms).
REQ-005 The block SHALL have port btn_ss, input, 1 bit: start/stop button, level, already debounced.
REQ-006 The block SHALL have port btn_lc, input, 1 bit: lap/clear button, level, already debounced.
REQ-007 The block SHALL have port disp, output, 4*NDIG bits: displayed BCD value, digit 0 (least significant) in bits [3:0].
REQ-008 The block SHALL have port running, output, 1 bit: high in RUN or LAP.
REQ-009 The block SHALL have port lap_active, output, 1 bit: high in LAP.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky wrap indicator.

Function
REQ-011 Each button SHALL be registered once; a press event SHALL be the button high while its register is low, i.e. one event per rising edge of the level.
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSE and LAP.
REQ-013 A btn_ss event SHALL cause these transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE.
REQ-014 A btn_lc event SHALL cause these transitions: RUN->LAP with the lap register captured; LAP->RUN; PAUSE->IDLE with count and overflow cleared; IDLE->IDLE with count and overflow cleared.
REQ-015 If btn_ss and btn_lc events occur in the same cycle, btn_ss SHALL win and btn_lc SHALL be discarded.
REQ-016 The transition for an event SHALL take effect at the clk edge where the event is seen, with outputs updated after that edge.
REQ-017 The internal count SHALL advance by 1 (decimal) at an edge with tick=1 only if the current (pre-edge) state is RUN or LAP.
REQ-018 The digit chain SHALL behave as follows: digit k increments when all lower digits are 9 and the count is enabled; a digit at 9 wraps to 0.
REQ-019 Digit values SHALL never leave 0..9.
REQ-020 When the count is all 9s and advances, it SHALL wrap to all 0s and set overflow, which SHALL stay high until cleared (REQ-014) or reset.
REQ-021 On a RUN->LAP event with tick in the same cycle, the lap register SHALL capture the post-increment value.
REQ-022 On a RUN->PAUSE or LAP->PAUSE event with tick in the same cycle, the tick SHALL be counted.
REQ-023 disp SHALL equal the lap register in LAP and the live count in every other state.
REQ-024 disp SHALL be driven directly from registers, with no combinational path from inputs.
REQ-025 Leaving LAP by either button SHALL immediately show the live count, which kept advancing during LAP.

Reset
REQ-026 While rst_asyn=1, the block SHALL immediately force: state=IDLE, count=0, lap register=0, overflow=0, button registers=0, disp=0, running=0, lap_active=0.
REQ-027 Reset mid-count SHALL discard all progress.
REQ-028 After release, a button already held high SHALL produce one event at the first edge.

Structure
REQ-029 The shared package bcd_pkg SHALL hold the state enumeration (2-bit: IDLE=0, RUN=1, PAUSE=2, LAP=3) and the constant BCD_MAX=4'd9.
REQ-030 The digit chain SHALL be built from NDIG instances of sub-module bcd_digit (ports: clk, rst_asyn, en, clr, q[3:0], carry), where carry = en and q==9.
REQ-031 The FSM, edge detection, lap register and overflow logic SHALL reside in bcd_stopwatch_ctrl.

Verification
REQ-032 Reset, btn_ss pulse, 12 ticks -> running=1, disp=0x0012.
REQ-033 In RUN at 0x0012, btn_lc, then 5 ticks -> lap_active=1, disp=0x0012 held; btn_lc again -> disp=0x0017, state RUN.
REQ-034 In RUN, btn_ss, 3 ticks, btn_lc -> ticks ignored (disp unchanged in PAUSE), then disp=0x0000, state IDLE, overflow=0.
REQ-035 Preload to 0x9998 via ticks in RUN, 2 ticks -> disp=0x0000, overflow=1; further btn_ss + btn_lc (clear) -> overflow=0.
REQ-036 btn_ss and btn_lc rising in the same cycle from RUN, with tick=1 -> state PAUSE, count incremented once, no lap capture.
REQ-037 btn_ss held high for 50 cycles -> exactly one transition.
REQ-038 rst_asyn pulsed for 1 ns between edges during RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD stopwatch controller.
//   state_t  : controller FSM state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   BCD_MAX  : largest legal value of a BCD digit
//   bcd_inc  : decimal increment of one digit with wrap from 9 to 0
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Anything at or above 9 wraps to 0, so the digit can never leave 0..9.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch counter.
//   clk      : clock, rising edge
//   rst_asyn : asynchronous active-high reset, forces q to 0
//   en       : advance this digit by one at the next edge
//   clr      : synchronous clear, has priority over en
//   q        : current BCD digit value (0..9)
//   carry    : en while the digit sits at 9, i.e. enable for the next digit
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_asyn,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= bcd_inc(q);
        end
    end

    assign carry = en && (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: start/stop and lap/clear buttons drive a
// four-state FSM that gates a cascaded BCD counter and a lap snapshot.
//   clk        : clock, rising edge
//   rst_asyn   : asynchronous active-high reset
//   tick       : one-cycle count strobe (time base)
//   btn_ss     : start/stop button level (debounced)
//   btn_lc     : lap/clear button level (debounced)
//   disp       : displayed BCD value, digit 0 in bits [3:0] (registered)
//   running    : high in RUN or LAP (registered)
//   lap_active : high in LAP (registered)
//   overflow   : sticky flag, set when the count wraps from all 9s to 0
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_asyn,
    input  logic              tick,
    input  logic              btn_ss,
    input  logic              btn_lc,
    output logic [4*NDIG-1:0] disp,
    output logic              running,
    output logic              lap_active,
    output logic              overflow
);

    state_t            state;
    logic              ss_reg;
    logic              lc_reg;
    logic              ss_ev;
    logic              lc_ev;
    logic              count_en;
    logic              clear;
    logic              wrap;
    logic [NDIG:0]     digit_en;
    logic [4*NDIG-1:0] count;
    logic [4*NDIG-1:0] count_next;
    logic [4*NDIG-1:0] live_next;
    logic [4*NDIG-1:0] lap_reg;

    // One event per rising edge of each button level. When both fire
    // together start/stop wins, so the lap/clear event is simply dropped.
    assign ss_ev = btn_ss && !ss_reg;
    assign lc_ev = btn_lc && !lc_reg && !ss_ev;

    // Counting depends only on the pre-edge state, so a tick arriving with
    // a RUN->PAUSE or LAP->PAUSE event is still counted.
    assign count_en = tick && ((state == RUN) || (state == LAP));
    assign clear    = lc_ev && ((state == IDLE) || (state == PAUSE));

    assign digit_en[0] = count_en;
    assign wrap        = digit_en[NDIG];

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst_asyn (rst_asyn),
                .en       (digit_en[gi]),
                .clr      (clear),
                .q        (count[4*gi +: 4]),
                .carry    (digit_en[gi+1])
            );

            // Value the digit will hold after this edge (ignoring clear);
            // used for the lap snapshot and the registered display.
            assign count_next[4*gi +: 4] = digit_en[gi] ? bcd_inc(count[4*gi +: 4])
                                                         : count[4*gi +: 4];
        end
    endgenerate

    assign live_next = clear ? '0 : count_next;

    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            state      <= IDLE;
            ss_reg     <= 1'b0;
            lc_reg     <= 1'b0;
            lap_reg    <= '0;
            overflow   <= 1'b0;
            disp       <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            ss_reg <= btn_ss;
            lc_reg <= btn_lc;

            if (clear) begin
                overflow <= 1'b0;
            end else if (wrap) begin
                overflow <= 1'b1;
            end

            // Display shows the post-edge live count unless we stay in or
            // enter LAP, which override below.
            disp <= live_next;

            case (state)
                IDLE: begin
                    if (ss_ev) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (ss_ev) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (lc_ev) begin
                        // Snapshot includes a tick arriving on this edge.
                        state      <= LAP;
                        lap_active <= 1'b1;
                        lap_reg    <= count_next;
                        disp       <= count_next;
                    end
                end
                PAUSE: begin
                    if (ss_ev) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (lc_ev) begin
                        state <= IDLE;
                    end
                end
                LAP: begin
                    if (ss_ev) begin
                        state      <= PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (lc_ev) begin
                        state      <= RUN;
                        lap_active <= 1'b0;
                    end else begin
                        disp <= lap_reg;
                    end
                end
                default: begin
                    state      <= IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
